// File: rtl/pid_cfg_sequencer_if.sv
// Local-bus bundle between the PID config sequencer (master) and the channel registers (slave).
interface pid_cfg_sequencer_if;
    logic [7:0]  Address;
    logic [31:0] DataOut;
    logic        Write;
    logic        Read;
    logic [31:0] BusIn;

    modport master (output Address, output DataOut, output Write, output Read, input BusIn);
    modport slave  (input Address, input DataOut, input Write, input Read, output BusIn);
endinterface

// File: rtl/pid_cfg_sequencer.sv
// Shadow table of PID channel registers, pushed to the local bus and then read back and verified.
module pid_cfg_sequencer #(
    parameter int unsigned NCH       = 4,
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       tbl_we,
    input  logic [7:0]                 tbl_idx,
    input  logic [31:0]                tbl_data,
    pid_cfg_sequencer_if.master        bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [7:0]                 err_addr
);
    localparam int unsigned NENT = 4 * NCH;
    localparam int unsigned IW   = $clog2(NENT);

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, CMP, FIN} state_e;

    // Power-on channel defaults, selected by register slot within a channel.
    function automatic logic [31:0] def_val(input logic [1:0] sel);
        case (sel)
            2'd0, 2'd1: def_val = 32'hFFFF_FFFF;
            2'd2:       def_val = 32'h0000_F000;
            default:    def_val = 32'h0F00_0000;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic [31:0]   tbl_q [NENT];
    logic [31:0]   tbl_d [NENT];
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic          write_q, write_d;
    logic          read_q, read_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [7:0]    err_addr_q, err_addr_d;
    logic          match, last, on_bus;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        tbl_d      = tbl_q;
        done_d     = 1'b0;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        match      = (bus.BusIn == tbl_q[idx_q]);
        last       = (idx_q == IW'(NENT - 1));

        if (tbl_we && !busy_q && ({1'b0, tbl_idx} < 9'(NENT)))
            tbl_d[tbl_idx[IW-1:0]] = tbl_data;

        case (state_q)
            IDLE: if (start) begin
                state_d    = WR;
                idx_d      = '0;
                err_d      = 1'b0;
                err_addr_d = 8'h00;
            end
            WR: begin
                if (last) begin
                    state_d = RD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            RD: begin
                wcnt_d  = 2'd0;
                state_d = (RD_LAT == 0) ? CMP : WAIT;
            end
            WAIT: begin
                if (wcnt_q == 2'(RD_LAT - 1)) state_d = CMP;
                else                          wcnt_d  = wcnt_q + 2'd1;
            end
            CMP: begin
                if (!match) begin
                    state_d    = FIN;
                    err_d      = 1'b1;
                    err_addr_d = BASE_ADDR + 8'(idx_q);
                end else if (last) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD;
                    idx_d   = idx_q + IW'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered.
        on_bus  = (state_d == WR) || (state_d == RD) || (state_d == WAIT) || (state_d == CMP);
        write_d = (state_d == WR);
        read_d  = on_bus && !write_d;
        busy_d  = on_bus;
        addr_d  = on_bus ? BASE_ADDR + 8'(idx_d) : 8'h00;
        dout_d  = write_d ? tbl_d[idx_d] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            wcnt_q     <= 2'd0;
            addr_q     <= 8'h00;
            dout_q     <= 32'h0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= 8'h00;
            for (int unsigned k = 0; k < NENT; k++)
                tbl_q[IW'(k)] <= def_val(2'(k));
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            write_q    <= write_d;
            read_q     <= read_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            tbl_q      <= tbl_d;
        end
    end

    assign bus.Address = addr_q;
    assign bus.DataOut = dout_q;
    assign bus.Write   = write_q;
    assign bus.Read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;
endmodule

// File: tb/tb_pid_cfg_sequencer.sv
// Scoreboard bench: A is NCH=4/BASE=00/RD_LAT=1 with registered echo, B is NCH=2/BASE=FC/RD_LAT=0 with combinational echo.
module tb_pid_cfg_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t q_a[$];
    txn_t q_b[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic        start_a = 1'b0, tbl_we_a = 1'b0;
    logic [7:0]  tbl_idx_a = 8'h00;
    logic [31:0] tbl_data_a = 32'h0;
    logic        busy_a, done_a, err_a;
    logic [7:0]  err_addr_a;
    logic        start_b = 1'b0, tbl_we_b = 1'b0;
    logic [7:0]  tbl_idx_b = 8'h00;
    logic [31:0] tbl_data_b = 32'h0;
    logic        busy_b, done_b, err_b;
    logic [7:0]  err_addr_b;

    pid_cfg_sequencer_if bus_a ();
    pid_cfg_sequencer_if bus_b ();

    pid_cfg_sequencer #(.NCH(4), .BASE_ADDR(8'h00), .RD_LAT(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .tbl_we(tbl_we_a), .tbl_idx(tbl_idx_a),
        .tbl_data(tbl_data_a), .bus(bus_a.master), .busy(busy_a), .done(done_a),
        .err(err_a), .err_addr(err_addr_a));

    pid_cfg_sequencer #(.NCH(2), .BASE_ADDR(8'hFC), .RD_LAT(0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .tbl_we(tbl_we_b), .tbl_idx(tbl_idx_b),
        .tbl_data(tbl_data_b), .bus(bus_b.master), .busy(busy_b), .done(done_b),
        .err(err_b), .err_addr(err_addr_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] def_val(input int k);
        case (k % 4)
            0, 1:    def_val = 32'hFFFF_FFFF;
            2:       def_val = 32'h0000_F000;
            default: def_val = 32'h0F00_0000;
        endcase
    endfunction

    // Channel register models: writes land in mem, reads echo mem (A can fault on address 0A).
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] mdl_a [16];
    logic        fault_en = 1'b0;
    int          done_cnt_a = 0;

    always @(posedge clk) begin
        if (bus_a.Write) mem_a[bus_a.Address] <= bus_a.DataOut;
        bus_a.BusIn <= (bus_a.Read && !(fault_en && bus_a.Address == 8'h0A)) ? mem_a[bus_a.Address] : 32'h0;
        if (bus_b.Write) mem_b[bus_b.Address] <= bus_b.DataOut;
    end
    assign bus_b.BusIn = bus_b.Read ? mem_b[bus_b.Address] : 32'h0;

    logic       prev_rd_a = 1'b0, prev_rd_b = 1'b0;
    logic [7:0] prev_ad_a = 8'h00, prev_ad_b = 8'h00;
    txn_t       ta, tb;

    // Monitors: each new write cycle or new read address pops one expected transaction.
    always @(negedge clk) begin
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (rst) begin
            if (bus_a.Write || (bus_a.Read && (!prev_rd_a || bus_a.Address != prev_ad_a))) begin
                check("a_rw_excl", 32'(bus_a.Write & bus_a.Read), 32'h0);
                if (q_a.size() == 0) check("a_extra_txn", 32'(bus_a.Address), 32'hFFFF_FFFF);
                else begin
                    ta = q_a.pop_front();
                    check("a_kind", 32'(bus_a.Write), 32'(ta.wr));
                    check("a_addr", 32'(bus_a.Address), 32'(ta.addr));
                    if (ta.wr) check("a_wdata", bus_a.DataOut, ta.data);
                end
            end
            if (!bus_a.Write) check("a_dout_idle", bus_a.DataOut, 32'h0);
            if (!busy_a) check("a_addr_idle", 32'(bus_a.Address), 32'h0);
            if (bus_b.Write || (bus_b.Read && (!prev_rd_b || bus_b.Address != prev_ad_b))) begin
                check("b_rw_excl", 32'(bus_b.Write & bus_b.Read), 32'h0);
                if (q_b.size() == 0) check("b_extra_txn", 32'(bus_b.Address), 32'hFFFF_FFFF);
                else begin
                    tb = q_b.pop_front();
                    check("b_kind", 32'(bus_b.Write), 32'(tb.wr));
                    check("b_addr", 32'(bus_b.Address), 32'(tb.addr));
                    if (tb.wr) check("b_wdata", bus_b.DataOut, tb.data);
                end
            end
        end
        prev_rd_a <= rst & bus_a.Read;
        prev_ad_a <= bus_a.Address;
        prev_rd_b <= rst & bus_b.Read;
        prev_ad_b <= bus_b.Address;
    end

    task automatic push_a(input int last_rd);
        for (int k = 0; k < 16; k++) q_a.push_back('{1'b1, 8'(k), mdl_a[k]});
        for (int k = 0; k <= last_rd; k++) q_a.push_back('{1'b0, 8'(k), 32'h0});
    endtask

    task automatic tbl_write_a(input logic [7:0] idx, input logic [31:0] data);
        tbl_we_a = 1'b1; tbl_idx_a = idx; tbl_data_a = data;
        @(negedge clk);
        tbl_we_a = 1'b0;
        if (idx < 8'd16) mdl_a[idx[3:0]] = data;
    endtask

    task automatic check_reset_outs();
        check("rst_a_ctl", 32'({bus_a.Address, bus_a.Write, bus_a.Read, busy_a, done_a, err_a, err_addr_a}), 32'h0);
        check("rst_a_dout", bus_a.DataOut, 32'h0);
        check("rst_b_ctl", 32'({bus_b.Address, bus_b.Write, bus_b.Read, busy_b, done_b, err_b, err_addr_b}), 32'h0);
        check("rst_b_dout", bus_b.DataOut, 32'h0);
    endtask

    // One start on A; poke pulses start/tbl_we mid-run, fail_idx >= 0 expects a mismatch there.
    task automatic run_a(input bit poke, input int fail_idx);
        int n, dc0;
        push_a(fail_idx < 0 ? 15 : fail_idx);
        dc0 = done_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 1;
        check("a_busy_rise", 32'(busy_a), 32'h1);
        check("a_err_clr", 32'(err_a), 32'h0);
        while (!done_a && !err_a && n < 300) begin
            if (poke && n == 20) begin
                start_a = 1'b1; tbl_we_a = 1'b1; tbl_idx_a = 8'd3; tbl_data_a = 32'h1234_5678;
            end
            @(negedge clk);
            n++;
            start_a = 1'b0; tbl_we_a = 1'b0;
        end
        if (fail_idx < 0) begin
            check("a_done", 32'(done_a), 32'h1);
            // start cycle counts as cycle 1
            check("a_done_cycle", 32'(n + 1), 32'(1 + 16 + 16 * 3 + 1));
            check("a_err", 32'(err_a), 32'h0);
        end else begin
            check("a_err", 32'(err_a), 32'h1);
            check("a_err_addr", 32'(err_addr_a), 32'(fail_idx));
            check("a_done_on_err", 32'(done_a), 32'h0);
        end
        check("a_busy_end", 32'(busy_a), 32'h0);
        @(negedge clk);
        check("a_done_pulse", 32'(done_a), 32'h0);
        repeat (4) @(negedge clk);
        check("a_q_empty", 32'(q_a.size()), 32'h0);
        check("a_done_count", 32'(done_cnt_a - dc0), (fail_idx < 0) ? 32'h1 : 32'h0);
        if (fail_idx >= 0) check("a_err_sticky", 32'(err_a), 32'h1);
    endtask

    task automatic abort_a(input int at);
        int n, dc0;
        push_a(15);
        dc0 = done_cnt_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 1;
        while (n < at) begin
            @(negedge clk);
            n++;
        end
        check("a_in_read", 32'(bus_a.Read), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs();
        rst = 1'b1;
        q_a.delete();
        for (int k = 0; k < 16; k++) mdl_a[k] = def_val(k);
        repeat (4) @(negedge clk);
        check("a_abort_done", 32'(done_cnt_a - dc0), 32'h0);
        check("a_abort_idle", 32'({busy_a, bus_a.Read, bus_a.Write}), 32'h0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 16; k++) mdl_a[k] = def_val(k);
        repeat (3) @(negedge clk);
        check_reset_outs();
        rst = 1'b1;
        @(negedge clk);

        run_a(1'b0, -1);
        tbl_write_a(8'd5, 32'h0000_0F0F);
        tbl_write_a(8'h10, 32'hDEAD_BEEF);
        run_a(1'b0, -1);
        run_a(1'b1, -1);
        fault_en = 1'b1;
        run_a(1'b0, 10);
        fault_en = 1'b0;
        abort_a(30);
        run_a(1'b0, -1);

        // B: wrapping base address, zero read latency
        for (int k = 0; k < 8; k++) q_b.push_back('{1'b1, 8'(8'hFC + 8'(k)), def_val(k)});
        for (int k = 0; k < 8; k++) q_b.push_back('{1'b0, 8'(8'hFC + 8'(k)), 32'h0});
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 1;
        while (!done_b && !err_b && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b_done", 32'(done_b), 32'h1);
        check("b_done_cycle", 32'(n + 1), 32'(1 + 8 + 8 * 2 + 1));
        check("b_err", 32'(err_b), 32'h0);
        repeat (3) @(negedge clk);
        check("b_q_empty", 32'(q_b.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
